// File: rtl/feature_map_collect.sv
// Reassembles a serialized feature-map stream into parallel vectors and queues them in a FIFO.
// Optional macro FEATURE_COLLECT_RELU_EN clamps negative channel values to zero at capture.
module feature_map_collect #(
    parameter int unsigned FEATURE_WIDTH = 16,
    parameter int unsigned FEATURE_DEPTH = 6,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_feature_valid,
    input  logic                                   i_feature_first,
    input  logic [FEATURE_WIDTH-1:0]               i_feature,
    output logic                                   o_feature_ready,
    output logic                                   o_features_valid,
    output logic [FEATURE_DEPTH*FEATURE_WIDTH-1:0] o_features,
    input  logic                                   i_features_ready,
    output logic                                   o_sync_err,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]        o_fifo_count
);

    localparam int unsigned ChW  = (FEATURE_DEPTH > 1) ? $clog2(FEATURE_DEPTH) : 1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned VecW = FEATURE_DEPTH * FEATURE_WIDTH;

    localparam logic [ChW-1:0]  LastCh  = ChW'(FEATURE_DEPTH - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StCollect} state_e;

    state_e                   state_q, state_d;
    logic [ChW-1:0]           ch_q, ch_d;
    logic                     sync_err_q, sync_err_d;
    logic [FEATURE_WIDTH-1:0] slot_q [FEATURE_DEPTH];
    logic [VecW-1:0]          mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]          count_q, count_d;

    logic                     beat_acc;
    logic                     slot_we;
    logic [ChW-1:0]           wr_idx;
    logic [FEATURE_WIDTH-1:0] cap_val;
    logic [VecW-1:0]          push_vec;
    logic                     push;
    logic                     pop;

`ifdef FEATURE_COLLECT_RELU_EN
    assign cap_val = i_feature[FEATURE_WIDTH-1] ? '0 : i_feature;
`else
    assign cap_val = i_feature;
`endif

    // Only the completing beat is gated by FIFO space; partial collection never stalls.
    assign o_feature_ready  = (ch_q != LastCh) || (count_q < FullCnt);
    assign beat_acc         = i_feature_valid & o_feature_ready;
    assign pop              = (count_q != '0) & i_features_ready;
    assign o_features_valid = (count_q != '0);
    assign o_features       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign o_fifo_count     = count_q;
    assign o_sync_err       = sync_err_q;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        sync_err_d = 1'b0;
        slot_we    = 1'b0;
        push       = 1'b0;
        wr_idx     = ch_q;
        if (beat_acc) begin
            unique case (state_q)
                StIdle: begin
                    if (i_feature_first) begin
                        wr_idx  = '0;
                        slot_we = 1'b1;
                        if (FEATURE_DEPTH == 1) begin
                            push = 1'b1;
                        end else begin
                            ch_d    = ChW'(1);
                            state_d = StCollect;
                        end
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
                StCollect: begin
                    if (i_feature_first) begin
                        // Restart: the partial vector is abandoned, this beat becomes channel 0.
                        sync_err_d = 1'b1;
                        wr_idx     = '0;
                        slot_we    = 1'b1;
                        ch_d       = ChW'(1);
                    end else begin
                        slot_we = 1'b1;
                        if (ch_q == LastCh) begin
                            push    = 1'b1;
                            ch_d    = '0;
                            state_d = StIdle;
                        end else begin
                            ch_d = ch_q + ChW'(1);
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    ch_d    = '0;
                end
            endcase
        end
    end

    // The completing beat bypasses the slot registers so the vector is pushed on the same edge.
    always_comb begin
        push_vec = '0;
        for (int c = 0; c < FEATURE_DEPTH; c++) begin
            push_vec[c*FEATURE_WIDTH +: FEATURE_WIDTH] =
                (ChW'(c) == wr_idx) ? cap_val : slot_q[c];
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            ch_q       <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            sync_err_q <= sync_err_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < FEATURE_DEPTH; c++) begin
                slot_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < FEATURE_DEPTH; c++) begin
                if (slot_we && (wr_idx == ChW'(c))) begin
                    slot_q[c] <= cap_val;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                mem_q[e] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_vec;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_feature_map_collect.sv
// Self-checking bench for feature_map_collect: queue-based stream model compared every cycle.
// Honours FEATURE_COLLECT_RELU_EN when defined for the whole build.
module tb_feature_map_collect;

    localparam int W  = 16;
    localparam int D  = 6;
    localparam int F  = 4;
    localparam int CW = 3;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic          i_feature_valid = 1'b0;
    logic          i_feature_first = 1'b0;
    logic [W-1:0]  i_feature = '0;
    logic          i_features_ready = 1'b0;
    logic          o_feature_ready;
    logic          o_features_valid;
    logic [D*W-1:0] o_features;
    logic          o_sync_err;
    logic [CW-1:0] o_fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: channels gathered so far, completed vectors awaiting the consumer, expected error pulse.
    logic [W-1:0]   part[$];
    logic [D*W-1:0] fifo_m[$];
    logic           m_err = 1'b0;

    logic [D*W+5:0] dut_bits;
    assign dut_bits = {o_features_valid, o_fifo_count, o_feature_ready, o_sync_err, o_features};

    always #5 i_clk = ~i_clk;

    feature_map_collect dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_feature_valid  (i_feature_valid),
        .i_feature_first  (i_feature_first),
        .i_feature        (i_feature),
        .o_feature_ready  (o_feature_ready),
        .o_features_valid (o_features_valid),
        .o_features       (o_features),
        .i_features_ready (i_features_ready),
        .o_sync_err       (o_sync_err),
        .o_fifo_count     (o_fifo_count)
    );

    function automatic logic [W-1:0] stored(input logic [W-1:0] d);
`ifdef FEATURE_COLLECT_RELU_EN
        if ($signed(d) < 0) return '0;
`endif
        return d;
    endfunction

    function automatic logic model_ready();
        return (part.size() != D - 1) || (fifo_m.size() < F);
    endfunction

    function automatic logic [D*W+5:0] model_bits();
        logic [D*W-1:0] v;
        logic [CW-1:0]  c;
        v = '0;
        if (fifo_m.size() != 0) v = fifo_m[0];
        c = CW'(fifo_m.size());
        return {fifo_m.size() != 0, c, model_ready(), m_err, v};
    endfunction

    function automatic logic [D*W-1:0] pack_part();
        logic [D*W-1:0] v;
        v = '0;
        for (int c = 0; c < D; c++) v[c*W +: W] = part[c];
        return v;
    endfunction

    // Drive one cycle from a falling edge, advance the model at the rising edge, return at the next fall.
    task automatic tick(input logic v, input logic f, input logic [W-1:0] d, input logic rdy,
                        output logic acc);
        logic           pop;
        logic [D*W-1:0] tmp;
        i_feature_valid  = v;
        i_feature_first  = f;
        i_feature        = d;
        i_features_ready = rdy;
        acc = v && model_ready();
        pop = (fifo_m.size() != 0) && rdy;
        @(posedge i_clk);
        if (pop) tmp = fifo_m.pop_front();
        m_err = 1'b0;
        if (acc) begin
            if (f) begin
                if (part.size() != 0) m_err = 1'b1;
                part.delete();
                part.push_back(stored(d));
            end else if (part.size() == 0) begin
                m_err = 1'b1;
            end else begin
                part.push_back(stored(d));
            end
            if (part.size() == D) begin
                fifo_m.push_back(pack_part());
                part.delete();
            end
        end
        @(negedge i_clk);
        i_feature_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 i_rst_n = 1'b0;
        part.delete();
        fifo_m.delete();
        m_err = 1'b0;
        @(negedge i_clk);
        n_tests++;
        if (dut_bits !== model_bits()) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", dut_bits, model_bits());
        end
        n_tests++;
        if (o_feature_ready !== 1'b1 || o_features !== '0) begin
            n_fail++;
            $display("FAIL reset_ready: got ready=%b feat=%h want ready=1 feat=0",
                     o_feature_ready, o_features);
        end
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_single_vector();
        logic acc;
        logic [D*W-1:0] exp_v;
        exp_v = {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        for (int k = 0; k < D; k++) begin
            tick(1'b1, k == 0, W'(k + 1), 1'b1, acc);
            n_tests++;
            if (dut_bits !== model_bits()) begin
                n_fail++;
                $display("FAIL single_lockstep beat%0d: got %h want %h", k, dut_bits, model_bits());
            end
        end
        n_tests++;
        if (o_features_valid !== 1'b1 || o_features !== exp_v) begin
            n_fail++;
            $display("FAIL single_vector: got v=%b %h want v=1 %h", o_features_valid, o_features, exp_v);
        end
        tick(1'b0, 1'b0, '0, 1'b1, acc);
        n_tests++;
        if (o_features_valid !== 1'b0 || o_fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL single_drain: got v=%b cnt=%0d want v=0 cnt=0", o_features_valid, o_fifo_count);
        end
    endtask

    task automatic test_backpressure();
        logic acc;
        logic [W-1:0] d;
        logic [D*W-1:0] cur;
        logic [D*W-1:0] sent[$];
        cur = '0;
        for (int v = 0; v < 5; v++) begin
            for (int c = 0; c < D; c++) begin
                d = W'($urandom);
                cur[c*W +: W] = stored(d);
                if (v == 4 && c == D - 1) begin
                    n_tests++;
                    if (o_feature_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL bp_ready_drop: got %b want 0", o_feature_ready);
                    end
                    repeat (3) begin
                        tick(1'b1, 1'b0, d, 1'b0, acc);
                        n_tests++;
                        if (dut_bits !== model_bits()) begin
                            n_fail++;
                            $display("FAIL bp_stall_lockstep: got %h want %h", dut_bits, model_bits());
                        end
                    end
                    n_tests++;
                    if (o_features !== sent[0]) begin
                        n_fail++;
                        $display("FAIL bp_head0: got %h want %h", o_features, sent[0]);
                    end
                    void'(sent.pop_front());
                    tick(1'b1, 1'b0, d, 1'b1, acc);
                    acc = 1'b0;
                    for (int t = 0; t < 10 && !acc; t++) tick(1'b1, 1'b0, d, 1'b0, acc);
                    n_tests++;
                    if (!acc || dut_bits !== model_bits()) begin
                        n_fail++;
                        $display("FAIL bp_resume: got acc=%b %h want acc=1 %h", acc, dut_bits, model_bits());
                    end
                end else begin
                    tick(1'b1, c == 0, d, 1'b0, acc);
                    n_tests++;
                    if (dut_bits !== model_bits()) begin
                        n_fail++;
                        $display("FAIL bp_lockstep v%0d c%0d: got %h want %h", v, c, dut_bits, model_bits());
                    end
                end
            end
            sent.push_back(cur);
            if (v == 3) begin
                n_tests++;
                if (o_fifo_count !== 3'd4) begin
                    n_fail++;
                    $display("FAIL bp_full_count: got %0d want 4", o_fifo_count);
                end
            end
        end
        for (int t = 0; t < 20 && sent.size() != 0; t++) begin
            n_tests++;
            if (o_features_valid !== 1'b1 || o_features !== sent[0]) begin
                n_fail++;
                $display("FAIL bp_drain_order: got v=%b %h want v=1 %h", o_features_valid, o_features, sent[0]);
            end
            void'(sent.pop_front());
            tick(1'b0, 1'b0, '0, 1'b1, acc);
        end
        n_tests++;
        if (o_fifo_count !== 3'd0 || dut_bits !== model_bits()) begin
            n_fail++;
            $display("FAIL bp_empty: got %h want %h", dut_bits, model_bits());
        end
    endtask

    task automatic test_framing();
        logic acc;
        logic [W-1:0] d;
        logic [D*W-1:0] exp_v;
        tick(1'b1, 1'b0, W'($urandom), 1'b1, acc);
        n_tests++;
        if (o_sync_err !== 1'b1 || o_fifo_count !== 3'd0 || dut_bits !== model_bits()) begin
            n_fail++;
            $display("FAIL frame_idle_err: got %h want %h", dut_bits, model_bits());
        end
        tick(1'b0, 1'b0, '0, 1'b1, acc);
        n_tests++;
        if (o_sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_pulse_width: got %b want 0", o_sync_err);
        end
        for (int k = 0; k < 3; k++) tick(1'b1, k == 0, W'($urandom), 1'b1, acc);
        exp_v = '0;
        for (int c = 0; c < D; c++) begin
            d = W'($urandom);
            exp_v[c*W +: W] = stored(d);
            tick(1'b1, c == 0, d, 1'b1, acc);
            if (c == 0) begin
                n_tests++;
                if (o_sync_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL frame_restart_err: got %b want 1", o_sync_err);
                end
            end
            n_tests++;
            if (dut_bits !== model_bits()) begin
                n_fail++;
                $display("FAIL frame_lockstep c%0d: got %h want %h", c, dut_bits, model_bits());
            end
        end
        n_tests++;
        if (o_features_valid !== 1'b1 || o_features !== exp_v) begin
            n_fail++;
            $display("FAIL frame_vector: got v=%b %h want v=1 %h", o_features_valid, o_features, exp_v);
        end
        tick(1'b0, 1'b0, '0, 1'b1, acc);
    endtask

    task automatic test_push_pop();
        logic acc;
        logic [W-1:0] d;
        logic [D*W-1:0] vecs[3];
        for (int v = 0; v < 3; v++) begin
            vecs[v] = '0;
            for (int c = 0; c < D; c++) begin
                d = W'($urandom);
                vecs[v][c*W +: W] = stored(d);
                tick(1'b1, c == 0, d, (v == 2 && c == D - 1), acc);
                n_tests++;
                if (dut_bits !== model_bits()) begin
                    n_fail++;
                    $display("FAIL pp_lockstep v%0d c%0d: got %h want %h", v, c, dut_bits, model_bits());
                end
            end
        end
        n_tests++;
        if (o_fifo_count !== 3'd2 || o_features !== vecs[1]) begin
            n_fail++;
            $display("FAIL pp_same_cycle: got cnt=%0d %h want cnt=2 %h", o_fifo_count, o_features, vecs[1]);
        end
        tick(1'b0, 1'b0, '0, 1'b1, acc);
        n_tests++;
        if (o_features !== vecs[2]) begin
            n_fail++;
            $display("FAIL pp_tail: got %h want %h", o_features, vecs[2]);
        end
        tick(1'b0, 1'b0, '0, 1'b1, acc);
    endtask

    task automatic test_reset_mid();
        logic acc;
        logic [W-1:0] d;
        logic [D*W-1:0] exp_v;
        for (int k = 0; k < 2 * D + 3; k++) tick(1'b1, (k % D) == 0, W'($urandom), 1'b0, acc);
        #2 i_rst_n = 1'b0;
        part.delete();
        fifo_m.delete();
        m_err = 1'b0;
        #1;
        n_tests++;
        if (o_features_valid !== 1'b0 || o_fifo_count !== 3'd0 || o_features !== '0 ||
            o_feature_ready !== 1'b1 || dut_bits !== model_bits()) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h want %h", dut_bits, model_bits());
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        exp_v = '0;
        for (int c = 0; c < D; c++) begin
            d = W'($urandom);
            exp_v[c*W +: W] = stored(d);
            tick(1'b1, c == 0, d, 1'b0, acc);
        end
        n_tests++;
        if (o_fifo_count !== 3'd1 || o_features !== exp_v) begin
            n_fail++;
            $display("FAIL mid_reset_vector: got cnt=%0d %h want cnt=1 %h", o_fifo_count, o_features, exp_v);
        end
        tick(1'b0, 1'b0, '0, 1'b1, acc);
        n_tests++;
        if (o_fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_reset_alone: got cnt=%0d want 0", o_fifo_count);
        end
    endtask

    task automatic test_relu();
        logic acc;
        logic [W-1:0] pat[D];
        logic [D*W-1:0] exp_v;
        pat = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h0010, 16'hFFF0};
`ifdef FEATURE_COLLECT_RELU_EN
        exp_v = {16'h0000, 16'h0010, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000};
`else
        exp_v = {16'hFFF0, 16'h0010, 16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
`endif
        for (int c = 0; c < D; c++) tick(1'b1, c == 0, pat[c], 1'b1, acc);
        n_tests++;
        if (o_features_valid !== 1'b1 || o_features !== exp_v) begin
            n_fail++;
            $display("FAIL relu_vector: got v=%b %h want v=1 %h", o_features_valid, o_features, exp_v);
        end
        tick(1'b0, 1'b0, '0, 1'b1, acc);
    endtask

    task automatic test_random();
        logic acc;
        logic nat;
        logic f;
        for (int k = 0; k < 400; k++) begin
            nat = (part.size() == 0);
            f = ($urandom_range(0, 15) == 0) ? !nat : nat;
            tick($urandom_range(0, 3) != 0, f, W'($urandom), $urandom_range(0, 2) == 0, acc);
            n_tests++;
            if (dut_bits !== model_bits()) begin
                n_fail++;
                $display("FAIL random_lockstep cyc%0d: got %h want %h", k, dut_bits, model_bits());
            end
        end
        for (int t = 0; t < 10; t++) tick(1'b0, 1'b0, '0, 1'b1, acc);
        n_tests++;
        if (o_fifo_count !== 3'd0 || dut_bits !== model_bits()) begin
            n_fail++;
            $display("FAIL random_drain: got %h want %h", dut_bits, model_bits());
        end
    endtask

    initial begin
        test_reset();
        test_single_vector();
        test_backpressure();
        test_framing();
        test_push_pop();
        test_reset_mid();
        test_relu();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
